// File: rtl/prio_enc_pkg.sv
// -----------------------------------------------------------------------------
// prio_enc_pkg
// Shared constants and types for the 4-to-2 priority encoder.
//   PRIO_N_IN  : number of request inputs
//   PRIO_OUT_W : width of the encoded index
//   prio_req_t : request vector type (bit 3 = highest priority)
//   prio_idx_t : encoded index type
// -----------------------------------------------------------------------------
package prio_enc_pkg;

    localparam int PRIO_N_IN  = 4;
    localparam int PRIO_OUT_W = 2;

    typedef logic [PRIO_N_IN-1:0]  prio_req_t;
    typedef logic [PRIO_OUT_W-1:0] prio_idx_t;

endpackage : prio_enc_pkg

// File: rtl/priority_encoder_core.sv
// -----------------------------------------------------------------------------
// priority_encoder_core
// Purely combinational 4-to-2 priority encode.
// Ports:
//   inputs     (in)  request vector, bit 3 highest priority
//   out_next   (out) index of the highest set request bit (00 when none set)
//   valid_next (out) 1 when any request bit is set
// -----------------------------------------------------------------------------
module priority_encoder_core
    import prio_enc_pkg::*;
(
    input  prio_req_t inputs,
    output prio_idx_t out_next,
    output logic      valid_next
);

    always_comb begin
        out_next   = '0;
        valid_next = 1'b0;
        // Descending priority: the first matching pattern wins, so lower
        // bits are don't-care once a higher bit is set.
        casez (inputs)
            4'b1???: begin
                out_next   = 2'd3;
                valid_next = 1'b1;
            end
            4'b01??: begin
                out_next   = 2'd2;
                valid_next = 1'b1;
            end
            4'b001?: begin
                out_next   = 2'd1;
                valid_next = 1'b1;
            end
            4'b0001: begin
                out_next   = 2'd0;
                valid_next = 1'b1;
            end
            default: begin
                out_next   = 2'd0;
                valid_next = 1'b0;
            end
        endcase
    end

endmodule : priority_encoder_core

// File: rtl/priority_encoder_4x2.sv
// -----------------------------------------------------------------------------
// priority_encoder_4x2
// Registered 4-to-2 priority encoder: combinational encode followed by a single
// register stage (1 clock latency).
// Parameters:
//   N_IN  number of request inputs (only 4 is supported)
//   OUT_W output index width (must be 2)
// Ports:
//   clk    (in)  system clock, rising edge
//   rst_n  (in)  asynchronous active-low reset
//   inputs (in)  request vector, bit 3 highest priority
//   out    (out) registered index of highest-priority set bit
//   valid  (out) registered flag, 1 when any request bit was set
// -----------------------------------------------------------------------------
module priority_encoder_4x2
    import prio_enc_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int OUT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IN-1:0]  inputs,
    output logic [OUT_W-1:0] out,
    output logic             valid
);

    if (N_IN != PRIO_N_IN || OUT_W != PRIO_OUT_W) begin : g_param_check
        $error("priority_encoder_4x2 supports only N_IN=4, OUT_W=2");
    end

    prio_idx_t out_d;
    logic      valid_d;
    prio_idx_t out_q;
    logic      valid_q;

    priority_encoder_core u_core (
        .inputs     (inputs),
        .out_next   (out_d),
        .valid_next (valid_d)
    );

    // Result register: cleared immediately on reset, so a sample pending at
    // reset assertion is simply lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out   = out_q;
    assign valid = valid_q;

endmodule : priority_encoder_4x2

// File: tb/tb_priority_encoder_4x2.sv
// -----------------------------------------------------------------------------
// tb_priority_encoder_4x2
// Scoreboard bench: the driver pushes the hand-computed expected {out, valid}
// when it applies a vector; the monitor pops one entry after every rising edge
// and compares against the registered outputs.
// -----------------------------------------------------------------------------
module tb_priority_encoder_4x2;

    logic       clk;
    logic       rst_n;
    logic [3:0] inputs;
    logic [1:0] out;
    logic       valid;

    int checks   = 0;
    int failures = 0;

    // Scoreboard entry: {applied inputs, expected out, expected valid}
    typedef struct packed {
        logic [3:0] in_v;
        logic [1:0] e_out;
        logic       e_valid;
    } sb_t;

    sb_t sb_q[$];

    // Hand-computed priority map indexed by the input value: {out, valid}
    logic [2:0] exp_tbl [16] = '{
        3'b000, 3'b001, 3'b011, 3'b011,
        3'b101, 3'b101, 3'b101, 3'b101,
        3'b111, 3'b111, 3'b111, 3'b111,
        3'b111, 3'b111, 3'b111, 3'b111
    };

    priority_encoder_4x2 #(
        .N_IN  (4),
        .OUT_W (2)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .inputs (inputs),
        .out    (out),
        .valid  (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check_now(input string name, input logic [1:0] e_out,
                             input logic e_valid);
        checks++;
        if (out !== e_out || valid !== e_valid) begin
            failures++;
            $display("FAIL %s got out=%b valid=%b expected out=%b valid=%b",
                     name, out, valid, e_out, e_valid);
        end
    endtask

    // Apply a vector at the falling edge; its result is due after the next
    // rising edge.
    task automatic apply(input logic [3:0] v, input logic [1:0] e_out,
                         input logic e_valid);
        sb_t e;
        @(negedge clk);
        inputs    = v;
        e.in_v    = v;
        e.e_out   = e_out;
        e.e_valid = e_valid;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    // Monitor
    always @(posedge clk) begin
        #1;
        if (sb_q.size() != 0) begin
            sb_t e;
            e = sb_q.pop_front();
            checks++;
            if (out !== e.e_out || valid !== e.e_valid) begin
                failures++;
                $display("FAIL sb in=%b got out=%b valid=%b expected out=%b valid=%b",
                         e.in_v, out, valid, e.e_out, e.e_valid);
            end
        end
    end

    initial begin
        logic [3:0] order [16];
        rst_n  = 1'b0;
        inputs = 4'b1111;

        // Reset held with all requests asserted
        repeat (3) begin
            @(posedge clk);
            #1;
            check_now("reset_hold", 2'b00, 1'b0);
        end

        // Release; first capture on the next rising edge
        @(negedge clk);
        rst_n = 1'b1;
        begin
            sb_t e;
            e.in_v = 4'b1111; e.e_out = 2'b11; e.e_valid = 1'b1;
            sb_q.push_back(e);
        end

        // One-hot sweep
        apply(4'b1000, 2'b11, 1'b1);
        apply(4'b0100, 2'b10, 1'b1);
        apply(4'b0010, 2'b01, 1'b1);
        apply(4'b0001, 2'b00, 1'b1);

        // Idle vs bit 0
        apply(4'b0000, 2'b00, 1'b0);
        apply(4'b0001, 2'b00, 1'b1);
        apply(4'b0000, 2'b00, 1'b0);

        // Multi-bit priority
        apply(4'b1100, 2'b11, 1'b1);
        apply(4'b0110, 2'b10, 1'b1);
        apply(4'b1111, 2'b11, 1'b1);
        apply(4'b0011, 2'b01, 1'b1);
        apply(4'b0000, 2'b00, 1'b0);
        drain();

        // Latency: change between edges, outputs hold until next rising edge
        @(negedge clk);
        inputs = 4'b0100;
        begin
            sb_t e;
            e.in_v = 4'b0100; e.e_out = 2'b10; e.e_valid = 1'b1;
            sb_q.push_back(e);
        end
        #1;
        check_now("latency_hold", 2'b00, 1'b0);
        drain();

        // Asynchronous reset mid-cycle
        @(posedge clk);
        #3;
        check_now("pre_async_reset", 2'b10, 1'b1);
        rst_n = 1'b0;
        #1;
        check_now("async_reset", 2'b00, 1'b0);
        @(posedge clk);
        #1;
        check_now("async_reset_edge", 2'b00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Exhaustive in shuffled order
        for (int i = 0; i < 16; i++) order[i] = 4'(i);
        for (int i = 15; i > 0; i--) begin
            int j;
            logic [3:0] t;
            j = $urandom_range(i, 0);
            t = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        for (int i = 0; i < 16; i++) begin
            logic [2:0] ev;
            ev = exp_tbl[order[i]];
            apply(order[i], ev[2:1], ev[0]);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_priority_encoder_4x2
